// File: rtl/i_mem_fetch_4t.sv
// i_mem_fetch_4t: four-thread barrel fetch stage.
// Round-robin PC fetch plus arbitrated external imem access.

module i_mem_fetch_4t #(
  parameter int          MSB_I_MEM = 11,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [3:0]         thread_en,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [1:0]         redirect_thread,
  input  logic [31:0]        redirect_pc,
  input  logic               ext_req_valid,
  input  logic               ext_req_wr,
  input  logic [MSB_I_MEM:0] ext_req_addr,
  input  logic [31:0]        ext_req_data,
  output logic               ext_req_ready,
  output logic               ext_rsp_valid,
  output logic [31:0]        ext_rsp_data,
  output logic [MSB_I_MEM:0] imem_address,
  output logic [31:0]        imem_data,
  output logic               imem_rden,
  output logic               imem_wren,
  input  logic [31:0]        imem_q,
  output logic               inst_valid,
  output logic [1:0]         inst_thread,
  output logic [31:0]        inst_pc,
  output logic [31:0]        inst
);

  localparam int AW = MSB_I_MEM + 1;

  localparam logic [31:0] PC_MASK =
    32'hFFFF_FFFC;

  localparam logic [AW-1:0] A_MASK =
    {{(AW-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic        valid;
    logic [1:0]  thread;
    logic [31:0] pc;
    logic        ext_rd;
  } tag_t;

  logic [31:0]   pc_q [4];
  logic [1:0]    rr_q;
  logic          ext_last_q;
  logic [AW-1:0] addr_q;
  tag_t          tag_q;
  tag_t          tag_d;

  logic          any_en;
  logic          slot_ok;
  logic          ext_sel;
  logic          fetch_sel;
  logic          fetch_kill;
  logic          fetch_go;
  logic [1:0]    ft;
  logic [31:0]   fetch_pc;
  logic [31:0]   redir_pc;
  logic [AW-1:0] ext_addr;
  logic          tag_kill;

  assign any_en   = |thread_en;
  assign ft       = rr_q;
  assign fetch_pc = pc_q[ft];
  assign redir_pc = redirect_pc & PC_MASK;
  assign ext_addr = ext_req_addr & A_MASK;

  // slot arbitration: external first unless it just had the slot
  always_comb begin
    slot_ok    = !rst && !stall;
    ext_sel    = slot_ok
              && ext_req_valid
              && !(ext_last_q && any_en);
    fetch_sel  = slot_ok && !ext_sel;
    fetch_kill = redirect_valid
              && (redirect_thread == ft);
    fetch_go   = fetch_sel
              && thread_en[ft]
              && !fetch_kill;
  end

  // redirect hits the instruction now in the tag register
  always_comb begin
    tag_kill = redirect_valid
            && tag_q.valid
            && (redirect_thread == tag_q.thread);
  end

  // imem port drive for the chosen slot; idle slots hold the address
  always_comb begin
    ext_req_ready = 1'b0;
    imem_rden     = 1'b0;
    imem_wren     = 1'b0;
    imem_address  = addr_q;
    imem_data     = ext_req_data;
    unique case (1'b1)
      ext_sel: begin
        ext_req_ready = 1'b1;
        imem_address  = ext_addr;
        imem_wren     = ext_req_wr;
        imem_rden     = !ext_req_wr;
      end
      fetch_go: begin
        imem_address  = fetch_pc[AW-1:0];
        imem_rden     = 1'b1;
      end
      default: ;
    endcase
  end

  // next stage-1 tag for the slot being issued
  always_comb begin
    tag_d        = '0;
    tag_d.valid  = fetch_go;
    tag_d.thread = ft;
    tag_d.pc     = fetch_pc;
    tag_d.ext_rd = ext_sel && !ext_req_wr;
  end

  // per-thread PCs: +4 on fetch, redirect overrides and ignores stall
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pc_q[i] <= RESET_PC & PC_MASK;
      end
    end else begin
      if (fetch_go) begin
        pc_q[ft] <= fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        pc_q[redirect_thread] <= redir_pc;
      end
    end
  end

  // round-robin pointer and external fairness flag
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rr_q       <= 2'd0;
      ext_last_q <= 1'b0;
    end else begin
      if (fetch_sel) begin
        rr_q <= rr_q + 2'd1;
      end
      if (ext_sel) begin
        ext_last_q <= 1'b1;
      end else if (fetch_sel) begin
        ext_last_q <= 1'b0;
      end
    end
  end

  // last driven address keeps imem_q stable across stalls
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= imem_address;
    end
  end

  // stage-1 tag: loads per slot, holds on stall, dropped by redirect
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else if (slot_ok) begin
      tag_q <= tag_d;
    end else if (tag_kill) begin
      tag_q.valid <= 1'b0;
    end
  end

  assign inst_valid    = tag_q.valid && !tag_kill;
  assign inst_thread   = tag_q.thread;
  assign inst_pc       = tag_q.pc;
  assign inst          = imem_q;
  assign ext_rsp_valid = tag_q.ext_rd;
  assign ext_rsp_data  = imem_q;

endmodule

// File: tb/tb_i_mem_fetch_4t.sv
// tb_i_mem_fetch_4t: scoreboard bench for the barrel fetch stage.
// Behavioural 4 KiB imem with one-cycle registered read.

module tb_i_mem_fetch_4t;

  logic        clock = 1'b0;
  logic        rst;
  logic [3:0]  thread_en;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_thread;
  logic [31:0] redirect_pc;
  logic        ext_req_valid;
  logic        ext_req_wr;
  logic [11:0] ext_req_addr;
  logic [31:0] ext_req_data;
  logic        ext_req_ready;
  logic        ext_rsp_valid;
  logic [31:0] ext_rsp_data;
  logic [11:0] imem_address;
  logic [31:0] imem_data;
  logic        imem_rden;
  logic        imem_wren;
  logic [31:0] imem_q;
  logic        inst_valid;
  logic [1:0]  inst_thread;
  logic [31:0] inst_pc;
  logic [31:0] inst;

  i_mem_fetch_4t dut (
    .clock           (clock),
    .rst             (rst),
    .thread_en       (thread_en),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_thread (redirect_thread),
    .redirect_pc     (redirect_pc),
    .ext_req_valid   (ext_req_valid),
    .ext_req_wr      (ext_req_wr),
    .ext_req_addr    (ext_req_addr),
    .ext_req_data    (ext_req_data),
    .ext_req_ready   (ext_req_ready),
    .ext_rsp_valid   (ext_rsp_valid),
    .ext_rsp_data    (ext_rsp_data),
    .imem_address    (imem_address),
    .imem_data       (imem_data),
    .imem_rden       (imem_rden),
    .imem_wren       (imem_wren),
    .imem_q          (imem_q),
    .inst_valid      (inst_valid),
    .inst_thread     (inst_thread),
    .inst_pc         (inst_pc),
    .inst            (inst)
  );

  always #5 clock = ~clock;

  logic [31:0] mem     [1024];
  logic [31:0] exp_mem [1024];

  always @(posedge clock) begin
    if (imem_wren) mem[imem_address[11:2]] <= imem_data;
    if (imem_rden) imem_q <= mem[imem_address[11:2]];
  end

  typedef struct {
    logic        v;
    logic [1:0]  th;
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] rsp_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  wire [66:0] tag_obs = inst_valid ?
    {1'b1, inst_thread, inst_pc, inst} : 67'd0;

  function automatic exp_t mk(logic v, logic [1:0] th, logic [31:0] pc);
    exp_t e;
    e.v  = v;
    e.th = th;
    e.pc = pc;
    e.w  = exp_mem[pc[11:2]];
    return e;
  endfunction

  function automatic logic [66:0] vec(exp_t e);
    return e.v ? {1'b1, e.th, e.pc, e.w} : 67'd0;
  endfunction

  task automatic apply_reset(input logic [3:0] en);
    rst = 1'b1;
    thread_en = en;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_thread = 2'd0;
    redirect_pc = 32'd0;
    ext_req_valid = 1'b0;
    ext_req_wr = 1'b0;
    ext_req_addr = 12'd0;
    ext_req_data = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(4'hF);
    rst = 1'b1;
    ext_req_valid = 1'b1;
    ext_req_addr = 12'h020;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_chk++;
    if ({inst_valid, ext_rsp_valid, ext_req_ready, imem_rden, imem_wren} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b exp 00000",
        {inst_valid, ext_rsp_valid, ext_req_ready, imem_rden, imem_wren});
    end
    n_chk++;
    if (imem_address !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_addr got %h exp 000", imem_address);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (ext_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ext_accept got %b exp 1", ext_req_ready);
    end
    @(posedge clock);
    #1;
    ext_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({ext_rsp_valid, inst_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_discard got %b exp 00", {ext_rsp_valid, inst_valid});
    end
  endtask

  task automatic test_fetch_all();
    exp_t e;
    apply_reset(4'hF);
    for (int i = 0; i < 12; i++)
      sb.push_back(mk(1'b1, 2'(i % 4), 32'(4 * (i / 4))));
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      n_chk++;
      if (tag_obs !== vec(e)) begin
        n_fail++;
        $display("FAIL fetch_all[%0d] got %h exp %h", i, tag_obs, vec(e));
      end
    end
  endtask

  task automatic test_thread_mask();
    exp_t e;
    apply_reset(4'b0101);
    for (int i = 0; i < 12; i++)
      sb.push_back(mk((i % 2) == 0, 2'(i % 4), 32'(4 * (i / 4))));
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      n_chk++;
      if (tag_obs !== vec(e)) begin
        n_fail++;
        $display("FAIL thread_mask[%0d] got %h exp %h", i, tag_obs, vec(e));
      end
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    logic [10:0] v  = 11'b11110111101;
    logic [31:0] pc [11] = '{0, 0, 0, 0, 4, 'h40, 4, 4, 8, 'h44, 'h80};
    apply_reset(4'hF);
    for (int i = 0; i < 11; i++)
      sb.push_back(mk(v[i], 2'(i % 4), pc[i]));
    for (int i = 0; i < 11; i++) begin
      @(posedge clock);
      @(negedge clock);
      redirect_valid = (i == 1) || (i == 5);
      redirect_thread = (i == 1) ? 2'd1 : 2'd2;
      redirect_pc = (i == 1) ? 32'h41 : 32'h83;
      #1;
      e = sb.pop_front();
      n_chk++;
      if (tag_obs !== vec(e)) begin
        n_fail++;
        $display("FAIL redirect[%0d] got %h exp %h", i, tag_obs, vec(e));
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_ext();
    logic [31:0] r;
    apply_reset(4'hF);
    ext_req_valid = 1'b1;
    ext_req_wr = 1'b1;
    ext_req_addr = 12'h013;
    ext_req_data = 32'hDEADBEEF;
    exp_mem[4] = 32'hDEADBEEF;
    #1;
    n_chk++;
    if ({ext_req_ready, imem_wren, imem_rden, imem_address} !== {3'b110, 12'h010}) begin
      n_fail++;
      $display("FAIL ext_write got %b_%h exp 110_010",
        {ext_req_ready, imem_wren, imem_rden}, imem_address);
    end
    @(posedge clock);
    @(negedge clock);
    ext_req_wr = 1'b0;
    ext_req_addr = 12'h012;
    #1;
    n_chk++;
    if ({ext_req_ready, imem_rden, imem_address, inst_valid} !== {2'b01, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL ext_alt_fetch got %b_%h_%b exp 01_000_0",
        {ext_req_ready, imem_rden}, imem_address, inst_valid);
    end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_chk++;
    if ({ext_req_ready, imem_rden, imem_wren, imem_address} !== {3'b110, 12'h010}) begin
      n_fail++;
      $display("FAIL ext_read_issue got %b_%h exp 110_010",
        {ext_req_ready, imem_rden, imem_wren}, imem_address);
    end
    n_chk++;
    if (tag_obs !== vec(mk(1'b1, 2'd0, 32'd0))) begin
      n_fail++;
      $display("FAIL ext_fetch_tag got %h exp %h", tag_obs, vec(mk(1'b1, 2'd0, 32'd0)));
    end
    rsp_q.push_back(32'hDEADBEEF);
    @(posedge clock);
    @(negedge clock);
    #1;
    n_chk++;
    if (ext_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_rsp_valid got %b exp 1", ext_rsp_valid);
    end else begin
      r = rsp_q.pop_front();
      if (ext_rsp_data !== r) begin
        n_fail++;
        $display("FAIL ext_rsp_data got %h exp %h", ext_rsp_data, r);
      end
    end
    n_chk++;
    if ({ext_req_ready, imem_rden, inst_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL ext_alt_held got %b exp 010", {ext_req_ready, imem_rden, inst_valid});
    end
    ext_req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_chk++;
    if ({ext_rsp_valid, tag_obs} !== {1'b0, vec(mk(1'b1, 2'd1, 32'd0))}) begin
      n_fail++;
      $display("FAIL ext_after got %b_%h exp 0_%h",
        ext_rsp_valid, tag_obs, vec(mk(1'b1, 2'd1, 32'd0)));
    end
    rsp_q.delete();
  endtask

  task automatic test_stall();
    exp_t e;
    exp_t h;
    apply_reset(4'hF);
    for (int i = 0; i < 6; i++)
      sb.push_back(mk(1'b1, 2'(i % 4), 32'(4 * (i / 4))));
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      n_chk++;
      if (tag_obs !== vec(e)) begin
        n_fail++;
        $display("FAIL stall_pre[%0d] got %h exp %h", i, tag_obs, vec(e));
      end
    end
    stall = 1'b1;
    ext_req_valid = 1'b1;
    ext_req_wr = 1'b0;
    ext_req_addr = 12'h020;
    h = mk(1'b1, 2'd1, 32'd4);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        @(posedge clock);
        @(negedge clock);
      end
      #1;
      n_chk++;
      if ({ext_req_ready, imem_rden, imem_wren, imem_address} !== {3'b000, 12'h004}) begin
        n_fail++;
        $display("FAIL stall_port[%0d] got %b_%h exp 000_004", j,
          {ext_req_ready, imem_rden, imem_wren}, imem_address);
      end
      n_chk++;
      if (tag_obs !== vec(h)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got %h exp %h", j, tag_obs, vec(h));
      end
    end
    stall = 1'b0;
    ext_req_valid = 1'b0;
    sb.push_back(mk(1'b1, 2'd2, 32'd4));
    sb.push_back(mk(1'b1, 2'd3, 32'd4));
    sb.push_back(mk(1'b1, 2'd0, 32'd8));
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      n_chk++;
      if (tag_obs !== vec(e)) begin
        n_fail++;
        $display("FAIL stall_post[%0d] got %h exp %h", i, tag_obs, vec(e));
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic rd;
    apply_reset(4'b0001);
    for (int c = 0; c < 10; c++) begin
      redirect_valid = (c == 0);
      redirect_thread = 2'd0;
      redirect_pc = 32'hFFFF_FFFF;
      #1;
      rd = (c == 4) || (c == 8);
      n_chk++;
      if (imem_rden !== rd || (rd && imem_address !== ((c == 4) ? 12'hFFC : 12'h000))) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d] got %b_%h exp %b_%h", c, imem_rden,
          imem_address, rd, (c == 4) ? 12'hFFC : 12'h000);
      end
      e = mk((c == 5) || (c == 9), 2'd0, (c == 5) ? 32'hFFFF_FFFC : 32'd0);
      n_chk++;
      if (tag_obs !== vec(e)) begin
        n_fail++;
        $display("FAIL wrap_tag[%0d] got %h exp %h", c, tag_obs, vec(e));
      end
      @(posedge clock);
      @(negedge clock);
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      exp_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    end
    imem_q = 32'd0;
    test_reset();
    test_fetch_all();
    test_thread_mask();
    test_redirect();
    test_ext();
    test_stall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i_mem_fetch_4t.md
# i_mem_fetch_4t

Four-thread barrel fetch stage sitting directly upstream of the instruction memory in the gpc_4t core. Each cycle it selects one hardware thread round-robin, drives that thread's PC as the instruction-memory address, and one cycle later presents the returned word tagged with thread ID and PC to decode. It also owns the only path for external (fabric/loader) reads and writes into instruction memory, arbitrating them against fetch with an anti-starvation rule.

## Interface
- MSB_I_MEM, 11, MSB of the instruction-memory byte address (memory is 2^(MSB_I_MEM+1) bytes).
- RESET_PC, 32'h0, PC loaded into every thread on reset; bits [1:0] must be 0.
- clock  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- thread_en  in  4  bit t enables fetch for thread t.
- stall  in  1  downstream hold; freezes the stage.
- redirect_valid  in  1  branch/jump redirect from execute.
- redirect_thread  in  2  thread being redirected.
- redirect_pc  in  32  new PC; bits [1:0] ignored.
- ext_req_valid  in  1  external access request.
- ext_req_wr  in  1  1 = write, 0 = read.
- ext_req_addr  in  MSB_I_MEM+1  byte address; bits [1:0] ignored.
- ext_req_data  in  32  write data.
- ext_req_ready  out  1  external request accepted this cycle.
- ext_rsp_valid  out  1  read data valid (reads only).
- ext_rsp_data  out  32  read data.
- imem_address  out  MSB_I_MEM+1  instruction-memory address, word aligned.
- imem_data  out  32  instruction-memory write data.
- imem_rden  out  1  fetch or external read slot.
- imem_wren  out  1  external write slot.
- imem_q  in  32  instruction-memory read data; registered, valid 1 cycle after the address.
- inst_valid  out  1  inst/inst_thread/inst_pc valid.
- inst_thread  out  2  thread of the presented instruction.
- inst_pc  out  32  PC of the presented instruction.
- inst  out  32  instruction word; passes imem_q through.

## Operation
- State:
  - pc[0..3], 32 bits each, with bits [1:0] held at 0.
  - rr_ptr, 2 bits.
  - Stage-1 tag register: valid, thread, pc, ext_rd.
  - ext_last flag, set when the previous slot went to external.
- Slot choice per non-stalled cycle, in priority order:
  - (a) External: when ext_req_valid && !(ext_last && any thread_en). Asserts ext_req_ready, imem_address = {ext_req_addr[MSB:2],2'b0}, imem_wren = ext_req_wr, imem_rden = !ext_req_wr. rr_ptr does not advance. Sets ext_last.
  - (b) Fetch: otherwise. Thread t = rr_ptr. If thread_en[t], drive imem_address = pc[t][MSB:0] and imem_rden = 1, then update pc[t] += 4. rr_ptr advances by 1 with wrap 3→0, whether or not the thread was enabled. Clears ext_last.
- Redirect: pc[redirect_thread] <= {redirect_pc[31:2],2'b0}. This is applied even during stall.
  - Same-cycle fetch of the same thread: the slot is killed (no rden, no tag), and the redirect value wins over +4.
  - In-flight tag of the same thread, either in stage 1 or held by stall: inst_valid is cleared.
- Stall: no slot is issued; imem_address holds its last value so that imem_q stays stable; the tag register, rr_ptr and ext_last hold; ext_req_ready = 0.
- PC arithmetic wraps modulo 2^32. The memory address wraps modulo memory size because only the low bits are used.
- Tag outputs:
  - inst_valid/inst_thread/inst_pc come from the stage-1 tag.
  - ext_rsp_valid = stage-1 ext_rd.
  - ext_rsp_data = imem_q.

## Timing
- Fetch latency is 1 cycle: address issued in cycle N appears as inst in cycle N+1.
- External read latency is 1 cycle: ext_rsp_valid pulses in the cycle after ext_req_ready.
- A write is complete at the edge ending its slot. A same-address read one cycle later returns the new data.
- Under continuous ext_req_valid with any thread enabled, external and fetch slots strictly alternate.
- Reset (asynchronous): pc[*] = RESET_PC, rr_ptr = 0, tag valid = 0, ext_last = 0.
  - Outputs: inst_valid = 0, ext_rsp_valid = 0, ext_req_ready = 0, imem_rden = 0, imem_wren = 0, imem_address = 0.
  - Reset mid-operation discards any in-flight fetch or external read; no response is produced.

## Test plan
- Reset with RESET_PC = 0, all threads enabled, no stall. inst_pc sequence from cycle 1 is t0:0, t1:0, t2:0, t3:0, then t0:4, t1:4, … with inst = word at each address.
- thread_en = 4'b0101. Only threads 0 and 2 are fetched. Every other cycle has inst_valid = 0, and the rr_ptr period stays 4.
- Redirect thread 1 to 0x40 in the same cycle thread 1 has a fetch in stage 1. That instruction is suppressed, and thread 1's next fetch is pc 0x40.
- External write of 0xDEADBEEF to 0x10, then a read of 0x10. ext_rsp_valid fires one cycle after the read is accepted with ext_rsp_data = 0xDEADBEEF. A held ext_req_valid alternates with fetch slots.
- Assert stall for 3 cycles while inst_valid = 1. inst, inst_pc and inst_thread are held constant, no PC advances, and ext_req_ready stays 0.
- Redirect to 0xFFFFFFFC, then let two fetches issue. pc wraps to 0x0 and imem_address = 0.
